// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit.
// Optional feature macro (used by instr_fetch_unit): IFU_PERF_CNT_EN.
package ifu_pkg;

    localparam int IFU_PC_W       = 16;
    localparam int IFU_INSTR_W    = 16;
    localparam int IFU_FIFO_DEPTH = 2;
    localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = 16'h0000;

    // Opcode field position, shared with the control unit
    localparam int OPCODE_MSB = IFU_INSTR_W - 1;
    localparam int OPCODE_LSB = IFU_INSTR_W - 4;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FLUSH
    } ifu_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [IFU_INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction memory bus and decode-side handshake of the fetch unit.
// master = fetch unit side, slave = memory/decode side.
interface ifu_if
    import ifu_pkg::*;
#(
    parameter int PC_W    = IFU_PC_W,
    parameter int INSTR_W = IFU_INSTR_W
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: small prefetch FIFO holding {instr_pc, instr}; clear empties it.
module ifu_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && (cnt == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, single-outstanding imem requester, prefetch
// buffer and redirect flush. Optional perf counters: IFU_PERF_CNT_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              PC_W       = IFU_PC_W,
    parameter int              INSTR_W    = IFU_INSTR_W,
    parameter int              FIFO_DEPTH = IFU_FIFO_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic            Clock,
    input  logic            Reset_n,
    ifu_if.master           bus,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e      state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] redir_tgt;
    logic [PC_W-1:0] pc_inc;
    logic            push, pop, fifo_empty, credit;
    logic [CW-1:0]   count, count_next;
    logic [PC_W+INSTR_W-1:0] head;

    assign redir_tgt  = {redirect_pc[PC_W-1:1], 1'b0};
    assign pc_inc     = fetch_pc_q + PC_W'(2);
    // Redirect wins over both pop and push in the same cycle
    assign pop        = !fifo_empty && bus.instr_ready && !redirect_valid;
    assign push       = (state_q == S_WAIT) && bus.imem_ack && !redirect_valid;
    // Credit is evaluated after the current request (if any) has completed
    assign count_next = count + CW'(push) - CW'(pop);
    assign credit     = count_next < CW'(FIFO_DEPTH);

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset_n),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.imem_addr, bus.imem_rdata}),
        .rdata (head),
        .count (count),
        .empty (fifo_empty)
    );

    // Next-state, next PC and next request; an issued request is never withdrawn
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                end else if (credit) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                    if (bus.imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (bus.imem_ack) begin
                    fetch_pc_d = pc_inc;
                    if (credit) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                end
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, PC and registered request outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_pc    = head[PC_W+INSTR_W-1:INSTR_W];
    assign bus.instr       = head[INSTR_W-1:0];

`ifdef IFU_PERF_CNT_EN
    // Saturating stall and redirect counters
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_stall_cnt <= '0;
            flush_cnt       <= '0;
        end else begin
            if (fifo_empty && (fetch_stall_cnt != '1)) begin
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            end
            if (redirect_valid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit.
// Memory model returns rdata = addr ^ 16'h5A00; ack is either tied to req
// (zero-wait) or driven by hand for multi-cycle latency.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        auto_ack = 1'b1;
    logic        ack_man = 1'b0;
    logic        ready = 1'b1;
    int          checks = 0;
    int          errors = 0;

    ifu_if bus ();

    assign bus.imem_ack    = auto_ack ? bus.imem_req : ack_man;
    assign bus.imem_rdata  = bus.imem_addr ^ 16'h5A00;
    assign bus.instr_ready = ready;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_fetch_unit dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_stall_cnt(fetch_stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #1 Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_addr",  {16'd0, bus.imem_addr},   32'h0000);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr},       32'h0000);
        chk("rst_pc",    {16'd0, bus.instr_pc},    32'h0000);
        tick();
        Reset_n = 1'b1;

        // Zero-wait memory, decode always ready
        tick();
        chk("zw_req1",  {31'd0, bus.imem_req},    32'd1);
        chk("zw_addr1", {16'd0, bus.imem_addr},   32'h0000);
        chk("zw_val1",  {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk("zw_addr2", {16'd0, bus.imem_addr},   32'h0002);
        chk("zw_val2",  {31'd0, bus.instr_valid}, 32'd1);
        chk("zw_ins2",  {16'd0, bus.instr},       32'h5A00);
        chk("zw_pc2",   {16'd0, bus.instr_pc},    32'h0000);
        tick();
        chk("zw_addr3", {16'd0, bus.imem_addr},   32'h0004);
        chk("zw_val3",  {31'd0, bus.instr_valid}, 32'd1);
        chk("zw_pc3",   {16'd0, bus.instr_pc},    32'h0002);

        // Backpressure: two words buffered, then requests stop
        ready = 1'b0;
        do_reset();
        tick();
        chk("bp_addr1", {16'd0, bus.imem_addr}, 32'h0000);
        tick();
        chk("bp_addr2", {16'd0, bus.imem_addr}, 32'h0002);
        tick();
        chk("bp_req_drop", {31'd0, bus.imem_req}, 32'd0);
        chk("bp_head_pc",  {16'd0, bus.instr_pc}, 32'h0000);
        tick();
        tick();
        tick();
        chk("bp_req_hold", {31'd0, bus.imem_req},    32'd0);
        chk("bp_valid",    {31'd0, bus.instr_valid}, 32'd1);
        chk("bp_head_pc2", {16'd0, bus.instr_pc},    32'h0000);
        ready = 1'b1;
        tick();
        chk("bp_pop_pc",  {16'd0, bus.instr_pc},  32'h0002);
        chk("bp_pop_ins", {16'd0, bus.instr},     32'h5A02);
        chk("bp_req3",    {31'd0, bus.imem_req},  32'd1);
        chk("bp_addr3",   {16'd0, bus.imem_addr}, 32'h0004);
        tick();
        chk("bp_next_pc", {16'd0, bus.instr_pc},  32'h0004);

        // 3-cycle latency memory, redirect while request outstanding
        auto_ack = 1'b0;
        ack_man  = 1'b0;
        do_reset();
        tick();
        chk("lat_req", {31'd0, bus.imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("fl_req_hold",  {31'd0, bus.imem_req},  32'd1);
        chk("fl_addr_hold", {16'd0, bus.imem_addr}, 32'h0000);
        tick();
        chk("fl_addr_hold2", {16'd0, bus.imem_addr}, 32'h0000);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("fl_req_off", {31'd0, bus.imem_req},    32'd0);
        chk("fl_dropped", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk("fl_new_req",  {31'd0, bus.imem_req},  32'd1);
        chk("fl_new_addr", {16'd0, bus.imem_addr}, 32'h0040);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("fl_first_val", {31'd0, bus.instr_valid}, 32'd1);
        chk("fl_first_pc",  {16'd0, bus.instr_pc},    32'h0040);
        chk("fl_first_ins", {16'd0, bus.instr},       32'h5A40);
        chk("fl_next_addr", {16'd0, bus.imem_addr},   32'h0042);

        // Redirect together with ack and pop
        ack_man        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        tick();
        ack_man        = 1'b0;
        redirect_valid = 1'b0;
        chk("rap_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rap_req",   {31'd0, bus.imem_req},    32'd0);
        tick();
        chk("rap_req2",  {31'd0, bus.imem_req},  32'd1);
        chk("rap_addr",  {16'd0, bus.imem_addr}, 32'h0100);

        // PC wrap at 0xFFFE
        auto_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wr_req_off", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("wr_addr_fffe", {16'd0, bus.imem_addr}, 32'hFFFE);
        tick();
        chk("wr_addr_0000", {16'd0, bus.imem_addr}, 32'h0000);
        chk("wr_head_pc",   {16'd0, bus.instr_pc},  32'hFFFE);
        chk("wr_head_ins",  {16'd0, bus.instr},     32'hA5FE);

        // Odd redirect target: bit 0 forced to zero
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0013;
        tick();
        redirect_valid = 1'b0;
        chk("odd_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk("odd_addr", {16'd0, bus.imem_addr}, 32'h0012);
        tick();
        chk("odd_pc",  {16'd0, bus.instr_pc}, 32'h0012);
        chk("odd_ins", {16'd0, bus.instr},    32'h5A12);

        // Asynchronous reset while a request is outstanding
        auto_ack = 1'b0;
        tick();
        chk("ar_pre_req",  {31'd0, bus.imem_req},  32'd1);
        chk("ar_pre_addr", {16'd0, bus.imem_addr}, 32'h0014);
        #2 Reset_n = 1'b0;
        #1;
        chk("ar_req",   {31'd0, bus.imem_req},    32'd0);
        chk("ar_addr",  {16'd0, bus.imem_addr},   32'h0000);
        chk("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("ar_instr", {16'd0, bus.instr},       32'h0000);
        chk("ar_pc",    {16'd0, bus.instr_pc},    32'h0000);
        auto_ack = 1'b1;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("ar_restart_req",  {31'd0, bus.imem_req},  32'd1);
        chk("ar_restart_addr", {16'd0, bus.imem_addr}, 32'h0000);
        tick();
        chk("ar_restart_pc", {16'd0, bus.instr_pc}, 32'h0000);

`ifdef IFU_PERF_CNT_EN
        chk("pc_flush0", flush_cnt, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        chk("pc_flush1", flush_cnt, 32'd1);
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("pc_flush2", flush_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
